// File: rtl/ram_2r1w_responder.sv
// Two-read/one-write kernel RAM responder with debug port,
// configurable read latency, zero-fill clear sequencer and drop counter.
module ram_2r1w_responder #(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 32,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] raddr0,
   output logic [WIDTH-1:0]  rdata0,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [WIDTH-1:0]  rdata1,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              wen,
   input  logic [ADDR_W-1:0] debug_write_addr,
   input  logic [WIDTH-1:0]  debug_write_data,
   input  logic              debug_write_en,
   input  logic [ADDR_W-1:0] debug_addr,
   output logic [WIDTH-1:0]  debug_data,
   input  logic              clear_req,
   output logic              busy,
   output logic [7:0]        drop_count
);

   localparam int NS = (READ_LAT == 0) ? 1 : READ_LAT;
   localparam logic [ADDR_W:0]   DEPTH_C = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_e;

   logic [WIDTH-1:0]  mem [DEPTH];

   state_e            state_q, state_d;
   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic [7:0]        drop_q, drop_d;
   logic [WIDTH-1:0]  dbg_q, dbg_d;
   logic [WIDTH-1:0]  p0_q [NS];
   logic [WIDTH-1:0]  p0_d [NS];
   logic [WIDTH-1:0]  p1_q [NS];
   logic [WIDTH-1:0]  p1_d [NS];

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [WIDTH-1:0]  mem_wdata;
   logic              k_ok;
   logic              k_drop;

   logic [WIDTH-1:0]  raw0, raw1, rawd;
   logic [WIDTH-1:0]  fwd0, fwd1, fwdd;

   function automatic logic in_rng(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < DEPTH_C;
   endfunction

   assign raw0 = in_rng(raddr0) ? mem[raddr0] : '0;
   assign raw1 = in_rng(raddr1) ? mem[raddr1] : '0;
   assign rawd = in_rng(debug_addr) ? mem[debug_addr] : '0;

   // Registered paths see the word as it will be after this edge's write.
   assign fwd0 = (mem_we && mem_waddr == raddr0) ? mem_wdata : raw0;
   assign fwd1 = (mem_we && mem_waddr == raddr1) ? mem_wdata : raw1;
   assign fwdd = (mem_we && mem_waddr == debug_addr) ? mem_wdata : rawd;

   assign k_ok = wen && !rst && in_rng(waddr);

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
      k_drop    = 1'b0;
      if (state_q == CLEAR) begin
         mem_we = 1'b1;
         k_drop = k_ok;
      end else if (debug_write_en) begin
         mem_we    = in_rng(debug_write_addr);
         mem_waddr = debug_write_addr;
         mem_wdata = debug_write_data;
         k_drop    = k_ok;
      end else if (k_ok) begin
         mem_we    = 1'b1;
         mem_waddr = waddr;
         mem_wdata = wdata;
      end
   end

   always_comb begin
      drop_d = drop_q;
      if (k_drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
   end

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      clr_ptr_d = clr_ptr_q;
      unique case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d   = CLEAR;
               busy_d    = 1'b1;
               clr_ptr_d = '0;
            end
         end
         CLEAR: begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_C) begin
               state_d   = IDLE;
               busy_d    = 1'b0;
               clr_ptr_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_comb begin
      dbg_d   = fwdd;
      p0_d[0] = fwd0;
      p1_d[0] = fwd1;
      for (int i = 1; i < NS; i++) begin
         p0_d[i] = p0_q[i-1];
         p1_d[i] = p1_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         clr_ptr_q <= '0;
         drop_q    <= '0;
         dbg_q     <= '0;
         p0_q      <= '{default: '0};
         p1_q      <= '{default: '0};
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         clr_ptr_q <= clr_ptr_d;
         drop_q    <= drop_d;
         dbg_q     <= dbg_d;
         p0_q      <= p0_d;
         p1_q      <= p1_d;
      end
   end

   // Array is deliberately outside reset so debug preloads work under rst.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign rdata0     = (READ_LAT == 0) ? raw0 : p0_q[NS-1];
   assign rdata1     = (READ_LAT == 0) ? raw1 : p1_q[NS-1];
   assign debug_data = dbg_q;
   assign busy       = busy_q;
   assign drop_count = drop_q;

endmodule
